target_round_controller: RTL and testbench

Hardware game sequencer for the target/photodiode datapath. Picks up to two lit targets from the random-number generator, times each target's hit window, samples the photodiode array for hits, and keeps the game score and game clock. Its score output feeds the four-digit score converter, and its target outputs drive the target LEDs. Game-loop timing moves out of processor software into deterministic RTL.

---
 rtl/target_round_if.sv | 27 ++
 rtl/target_round_controller.sv | 182 ++++++++++++++++++
 tb/tb_target_round_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/target_round_if.sv
// Game I/O bundle between the target round controller and its environment.
// slave = controller side, master = the side driving RNG/photodiode inputs.
interface target_round_if;
    logic        start;
    logic [3:0]  rand_num;
    logic [9:0]  photo_array;
    logic [3:0]  target_a;
    logic [3:0]  target_b;
    logic        hit_a;
    logic        hit_b;
    logic [31:0] score;
    logic [7:0]  miss_count;
    logic        game_active;
    logic        game_over;

    modport slave (
        input  start, rand_num, photo_array,
        output target_a, target_b, hit_a, hit_b, score, miss_count,
               game_active, game_over
    );

    modport master (
        output start, rand_num, photo_array,
        input  target_a, target_b, hit_a, hit_b, score, miss_count,
               game_active, game_over
    );
endinterface

// File: rtl/target_round_controller.sv
// Two-slot target game sequencer: arms targets from the RNG, times hit windows, keeps score/clock.
// All outputs registered; a beam edge scores 3 edges after arrival; no backpressure (free-running).
module target_round_controller #(
    parameter int unsigned HIT_WINDOW  = 50000000,
    parameter int unsigned GAME_CYCLES = 1500000000,
    parameter int unsigned POINTS      = 10,
    parameter int unsigned SCORE_MAX   = 9999
) (
    input  logic         clock,
    input  logic         reset,
    target_round_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;
    typedef enum logic {SL_EMPTY, SL_ARMED} slot_t;

    localparam logic [31:0] WIN_LOAD  = 32'(HIT_WINDOW - 1);
    localparam logic [31:0] GAME_LOAD = 32'(GAME_CYCLES - 1);
    localparam logic [32:0] PTS       = 33'(POINTS);
    localparam logic [32:0] SAT       = 33'(SCORE_MAX);
    localparam logic [3:0]  NONE      = 4'hF;

    state_t      state_q,    state_d;
    slot_t       slot_a_q,   slot_a_d;
    slot_t       slot_b_q,   slot_b_d;
    logic [3:0]  tgt_a_q,    tgt_a_d;
    logic [3:0]  tgt_b_q,    tgt_b_d;
    logic [31:0] win_a_q,    win_a_d;
    logic [31:0] win_b_q,    win_b_d;
    logic [31:0] game_cnt_q, game_cnt_d;
    logic [31:0] score_q,    score_d;
    logic [7:0]  miss_q,     miss_d;
    logic        hit_a_q,    hit_a_d;
    logic        hit_b_q,    hit_b_d;
    logic [9:0]  psync1_q,   psync1_d;
    logic [9:0]  psync_q,    psync_d;

    logic        rand_ok;
    logic        hit_a_ev, miss_a_ev, hit_b_ev, miss_b_ev;
    logic [32:0] delta, score_sum;
    logic [8:0]  miss_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            slot_a_q   <= SL_EMPTY;
            slot_b_q   <= SL_EMPTY;
            tgt_a_q    <= NONE;
            tgt_b_q    <= NONE;
            win_a_q    <= '0;
            win_b_q    <= '0;
            game_cnt_q <= '0;
            score_q    <= '0;
            miss_q     <= '0;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            psync1_q   <= '0;
            psync_q    <= '0;
        end else begin
            state_q    <= state_d;
            slot_a_q   <= slot_a_d;
            slot_b_q   <= slot_b_d;
            tgt_a_q    <= tgt_a_d;
            tgt_b_q    <= tgt_b_d;
            win_a_q    <= win_a_d;
            win_b_q    <= win_b_d;
            game_cnt_q <= game_cnt_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
            psync1_q   <= psync1_d;
            psync_q    <= psync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_a_d   = slot_a_q;
        slot_b_d   = slot_b_q;
        tgt_a_d    = tgt_a_q;
        tgt_b_d    = tgt_b_q;
        win_a_d    = win_a_q;
        win_b_d    = win_b_q;
        game_cnt_d = game_cnt_q;
        score_d    = score_q;
        miss_d     = miss_q;
        hit_a_d    = 1'b0;
        hit_b_d    = 1'b0;
        psync1_d   = bus.photo_array;
        psync_d    = psync1_q;
        rand_ok    = (bus.rand_num <= 4'd9);
        hit_a_ev   = 1'b0;
        miss_a_ev  = 1'b0;
        hit_b_ev   = 1'b0;
        miss_b_ev  = 1'b0;
        delta      = '0;
        score_sum  = '0;
        miss_sum   = '0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    score_d    = '0;
                    miss_d     = '0;
                    game_cnt_d = GAME_LOAD;
                    slot_a_d   = SL_EMPTY;
                    slot_b_d   = SL_EMPTY;
                    tgt_a_d    = NONE;
                    tgt_b_d    = NONE;
                end
            end

            ST_RUN: begin
                // Slot A: a beam on the final window cycle still wins over the timeout.
                if (slot_a_q == SL_ARMED) begin
                    if (psync_q[tgt_a_q])      hit_a_ev  = 1'b1;
                    else if (win_a_q == '0)    miss_a_ev = 1'b1;
                    else                       win_a_d   = win_a_q - 32'd1;
                    if (hit_a_ev || miss_a_ev) begin
                        slot_a_d = SL_EMPTY;
                        tgt_a_d  = NONE;
                    end
                end else if (rand_ok && (bus.rand_num != tgt_b_q)) begin
                    slot_a_d = SL_ARMED;
                    tgt_a_d  = bus.rand_num;
                    win_a_d  = WIN_LOAD;
                end

                // Slot B also yields to a value slot A is grabbing on this same edge.
                if (slot_b_q == SL_ARMED) begin
                    if (psync_q[tgt_b_q])      hit_b_ev  = 1'b1;
                    else if (win_b_q == '0)    miss_b_ev = 1'b1;
                    else                       win_b_d   = win_b_q - 32'd1;
                    if (hit_b_ev || miss_b_ev) begin
                        slot_b_d = SL_EMPTY;
                        tgt_b_d  = NONE;
                    end
                end else if (rand_ok && (bus.rand_num != tgt_a_q) &&
                             (bus.rand_num != tgt_a_d)) begin
                    slot_b_d = SL_ARMED;
                    tgt_b_d  = bus.rand_num;
                    win_b_d  = WIN_LOAD;
                end

                delta     = (hit_a_ev ? PTS : 33'd0) + (hit_b_ev ? PTS : 33'd0);
                score_sum = {1'b0, score_q} + delta;
                score_d   = (score_sum > SAT) ? SAT[31:0] : score_sum[31:0];
                miss_sum  = {1'b0, miss_q} + {8'd0, miss_a_ev} + {8'd0, miss_b_ev};
                miss_d    = (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];
                hit_a_d   = hit_a_ev;
                hit_b_d   = hit_b_ev;

                // Final-cycle hits/misses above are kept; only targets and pulses are cleared.
                if (game_cnt_q == '0) begin
                    state_d  = ST_OVER;
                    slot_a_d = SL_EMPTY;
                    slot_b_d = SL_EMPTY;
                    tgt_a_d  = NONE;
                    tgt_b_d  = NONE;
                    hit_a_d  = 1'b0;
                    hit_b_d  = 1'b0;
                end else begin
                    game_cnt_d = game_cnt_q - 32'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.target_a    = tgt_a_q;
    assign bus.target_b    = tgt_b_q;
    assign bus.hit_a       = hit_a_q;
    assign bus.hit_b       = hit_b_q;
    assign bus.score       = score_q;
    assign bus.miss_count  = miss_q;
    assign bus.game_active = (state_q == ST_RUN);
    assign bus.game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_target_round_controller.sv
// Directed bench: a small-window/short-game instance for the main scenarios and a
// second instance with POINTS=5 so the score can be walked to 9995 and saturated.
module tb_target_round_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clock = ~clock;

    target_round_if ifc ();
    target_round_if ifc_s ();

    target_round_controller #(
        .HIT_WINDOW(20), .GAME_CYCLES(100), .POINTS(10), .SCORE_MAX(9999)
    ) dut (
        .clock(clock), .reset(reset), .bus(ifc)
    );

    target_round_controller #(
        .HIT_WINDOW(20), .GAME_CYCLES(20000), .POINTS(5), .SCORE_MAX(9999)
    ) dut_sat (
        .clock(clock), .reset(reset), .bus(ifc_s)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        ifc.start         = 1'b0;
        ifc.rand_num      = 4'd15;
        ifc.photo_array   = '0;
        ifc_s.start       = 1'b0;
        ifc_s.rand_num    = 4'd15;
        ifc_s.photo_array = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic start_game();
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.start       = ~ifc.start;
            ifc.photo_array = ~ifc.photo_array;
            tick(1);
        end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL rst_target_a got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.target_b !== 4'hF) begin nfail++; $display("FAIL rst_target_b got=%h exp=f", ifc.target_b); end
        nvec++; if (ifc.hit_a !== 1'b0) begin nfail++; $display("FAIL rst_hit_a got=%b exp=0", ifc.hit_a); end
        nvec++; if (ifc.hit_b !== 1'b0) begin nfail++; $display("FAIL rst_hit_b got=%b exp=0", ifc.hit_b); end
        nvec++; if (ifc.score !== 32'd0) begin nfail++; $display("FAIL rst_score got=%0d exp=0", ifc.score); end
        nvec++; if (ifc.miss_count !== 8'd0) begin nfail++; $display("FAIL rst_miss got=%0d exp=0", ifc.miss_count); end
        nvec++; if (ifc.game_active !== 1'b0) begin nfail++; $display("FAIL rst_active got=%b exp=0", ifc.game_active); end
        nvec++; if (ifc.game_over !== 1'b0) begin nfail++; $display("FAIL rst_over got=%b exp=0", ifc.game_over); end
        idle_inputs();
        reset = 1'b1;
        tick(3);
        nvec++; if (ifc.game_active !== 1'b0) begin nfail++; $display("FAIL idle_active got=%b exp=0", ifc.game_active); end
        nvec++; if (ifc.game_over !== 1'b0) begin nfail++; $display("FAIL idle_over got=%b exp=0", ifc.game_over); end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL idle_target_a got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.target_b !== 4'hF) begin nfail++; $display("FAIL idle_target_b got=%h exp=f", ifc.target_b); end
    endtask

    task automatic test_arm_hit();
        do_reset();
        start_game();
        nvec++; if (ifc.game_active !== 1'b1) begin nfail++; $display("FAIL run_active got=%b exp=1", ifc.game_active); end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL run_entry_tgt got=%h exp=f", ifc.target_a); end
        ifc.rand_num = 4'd3;
        tick(1);
        nvec++; if (ifc.target_a !== 4'd3) begin nfail++; $display("FAIL arm_target_a got=%h exp=3", ifc.target_a); end
        nvec++; if (ifc.target_b !== 4'hF) begin nfail++; $display("FAIL arm_target_b got=%h exp=f", ifc.target_b); end
        ifc.rand_num       = 4'd15;
        ifc.photo_array[3] = 1'b1;
        tick(2);
        nvec++; if (ifc.hit_a !== 1'b0) begin nfail++; $display("FAIL hit_early got=%b exp=0", ifc.hit_a); end
        tick(1);
        nvec++; if (ifc.hit_a !== 1'b1) begin nfail++; $display("FAIL hit_pulse got=%b exp=1", ifc.hit_a); end
        nvec++; if (ifc.hit_b !== 1'b0) begin nfail++; $display("FAIL hit_b_idle got=%b exp=0", ifc.hit_b); end
        nvec++; if (ifc.score !== 32'd10) begin nfail++; $display("FAIL hit_score got=%0d exp=10", ifc.score); end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL hit_clear got=%h exp=f", ifc.target_a); end
        tick(1);
        nvec++; if (ifc.hit_a !== 1'b0) begin nfail++; $display("FAIL hit_one_cycle got=%b exp=0", ifc.hit_a); end
        ifc.photo_array = '0;
    endtask

    task automatic test_invalid_dup();
        do_reset();
        ifc.rand_num = 4'd12;
        start_game();
        tick(5);
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL inval_target_a got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.target_b !== 4'hF) begin nfail++; $display("FAIL inval_target_b got=%h exp=f", ifc.target_b); end
        ifc.rand_num = 4'd7;
        tick(4);
        nvec++; if (ifc.target_a !== 4'd7) begin nfail++; $display("FAIL dup_target_a got=%h exp=7", ifc.target_a); end
        nvec++; if (ifc.target_b !== 4'hF) begin nfail++; $display("FAIL dup_target_b got=%h exp=f", ifc.target_b); end
        ifc.rand_num = 4'd2;
        tick(1);
        nvec++; if (ifc.target_b !== 4'd2) begin nfail++; $display("FAIL b_arm got=%h exp=2", ifc.target_b); end
        nvec++; if (ifc.target_a !== 4'd7) begin nfail++; $display("FAIL a_hold got=%h exp=7", ifc.target_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        start_game();
        ifc.rand_num = 4'd5;
        tick(1);
        ifc.rand_num = 4'd15;
        tick(19);
        nvec++; if (ifc.target_a !== 4'd5) begin nfail++; $display("FAIL to_hold got=%h exp=5", ifc.target_a); end
        nvec++; if (ifc.miss_count !== 8'd0) begin nfail++; $display("FAIL to_early_miss got=%0d exp=0", ifc.miss_count); end
        tick(1);
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL to_clear got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.miss_count !== 8'd1) begin nfail++; $display("FAIL to_miss got=%0d exp=1", ifc.miss_count); end
        ifc.rand_num = 4'd6;
        tick(1);
        ifc.rand_num = 4'd15;
        tick(17);
        ifc.photo_array[6] = 1'b1;
        tick(2);
        nvec++; if (ifc.target_a !== 4'd6) begin nfail++; $display("FAIL last_win_hold got=%h exp=6", ifc.target_a); end
        tick(1);
        nvec++; if (ifc.hit_a !== 1'b1) begin nfail++; $display("FAIL last_win_hit got=%b exp=1", ifc.hit_a); end
        nvec++; if (ifc.miss_count !== 8'd1) begin nfail++; $display("FAIL last_win_miss got=%0d exp=1", ifc.miss_count); end
        nvec++; if (ifc.score !== 32'd10) begin nfail++; $display("FAIL last_win_score got=%0d exp=10", ifc.score); end
        ifc.photo_array = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        ifc_s.photo_array = 10'h002;
        ifc_s.start       = 1'b1;
        tick(1);
        ifc_s.start = 1'b0;
        tick(2);
        for (int i = 0; i < 1999; i++) begin
            ifc_s.rand_num = 4'd1;
            tick(1);
            ifc_s.rand_num = 4'd15;
            tick(1);
        end
        nvec++; if (ifc_s.score !== 32'd9995) begin nfail++; $display("FAIL preload_score got=%0d exp=9995", ifc_s.score); end
        ifc_s.photo_array = '0;
        tick(3);
        ifc_s.rand_num = 4'd1;
        tick(1);
        ifc_s.rand_num = 4'd4;
        tick(1);
        ifc_s.rand_num = 4'd15;
        nvec++; if (ifc_s.target_a !== 4'd1) begin nfail++; $display("FAIL sat_target_a got=%h exp=1", ifc_s.target_a); end
        nvec++; if (ifc_s.target_b !== 4'd4) begin nfail++; $display("FAIL sat_target_b got=%h exp=4", ifc_s.target_b); end
        ifc_s.photo_array = 10'h012;
        tick(3);
        nvec++; if (ifc_s.hit_a !== 1'b1) begin nfail++; $display("FAIL dbl_hit_a got=%b exp=1", ifc_s.hit_a); end
        nvec++; if (ifc_s.hit_b !== 1'b1) begin nfail++; $display("FAIL dbl_hit_b got=%b exp=1", ifc_s.hit_b); end
        nvec++; if (ifc_s.score !== 32'd9999) begin nfail++; $display("FAIL sat_score got=%0d exp=9999", ifc_s.score); end
        nvec++; if (ifc_s.miss_count !== 8'd0) begin nfail++; $display("FAIL sat_miss got=%0d exp=0", ifc_s.miss_count); end
        ifc_s.photo_array = '0;
    endtask

    task automatic test_game_end();
        do_reset();
        ifc.photo_array[8] = 1'b1;
        start_game();
        ifc.rand_num = 4'd8;
        tick(1);
        ifc.rand_num = 4'd15;
        tick(1);
        nvec++; if (ifc.score !== 32'd10) begin nfail++; $display("FAIL ge_score got=%0d exp=10", ifc.score); end
        ifc.rand_num = 4'd9;
        tick(97);
        nvec++; if (ifc.game_over !== 1'b0) begin nfail++; $display("FAIL ge_over_early got=%b exp=0", ifc.game_over); end
        nvec++; if (ifc.target_a !== 4'd9) begin nfail++; $display("FAIL ge_target_live got=%h exp=9", ifc.target_a); end
        nvec++; if (ifc.miss_count !== 8'd4) begin nfail++; $display("FAIL ge_miss got=%0d exp=4", ifc.miss_count); end
        tick(1);
        nvec++; if (ifc.game_over !== 1'b1) begin nfail++; $display("FAIL ge_over got=%b exp=1", ifc.game_over); end
        nvec++; if (ifc.game_active !== 1'b0) begin nfail++; $display("FAIL ge_active got=%b exp=0", ifc.game_active); end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL ge_target_clr got=%h exp=f", ifc.target_a); end
        tick(5);
        nvec++; if (ifc.score !== 32'd10) begin nfail++; $display("FAIL ge_frozen_score got=%0d exp=10", ifc.score); end
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL ge_no_arm got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.miss_count !== 8'd4) begin nfail++; $display("FAIL ge_frozen_miss got=%0d exp=4", ifc.miss_count); end
        ifc.rand_num = 4'd15;
        start_game();
        nvec++; if (ifc.game_active !== 1'b1) begin nfail++; $display("FAIL rs_active got=%b exp=1", ifc.game_active); end
        nvec++; if (ifc.score !== 32'd0) begin nfail++; $display("FAIL rs_score got=%0d exp=0", ifc.score); end
        nvec++; if (ifc.miss_count !== 8'd0) begin nfail++; $display("FAIL rs_miss got=%0d exp=0", ifc.miss_count); end
        ifc.rand_num = 4'd8;
        tick(1);
        ifc.rand_num = 4'd15;
        tick(1);
        ifc.rand_num = 4'd2;
        tick(1);
        nvec++; if (ifc.target_a !== 4'd2) begin nfail++; $display("FAIL rs_arm got=%h exp=2", ifc.target_a); end
        #3;
        reset = 1'b0;
        #1;
        nvec++; if (ifc.target_a !== 4'hF) begin nfail++; $display("FAIL mid_rst_tgt got=%h exp=f", ifc.target_a); end
        nvec++; if (ifc.score !== 32'd0) begin nfail++; $display("FAIL mid_rst_score got=%0d exp=0", ifc.score); end
        nvec++; if (ifc.game_active !== 1'b0) begin nfail++; $display("FAIL mid_rst_active got=%b exp=0", ifc.game_active); end
        reset = 1'b1;
        tick(2);
        nvec++; if (ifc.game_active !== 1'b0) begin nfail++; $display("FAIL post_rst_idle got=%b exp=0", ifc.game_active); end
    endtask

    initial begin
        test_reset();
        test_arm_hit();
        test_invalid_dup();
        test_timeout();
        test_saturation();
        test_game_end();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
